// File: rtl/region_vote_smoother.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | region_vote_smoother                                                     |
// | Per-frame region voting on the object centroid over a WINDOW-frame       |
// | window; issues a one-hot region decision plus an update pulse.           |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module region_vote_smoother #(
    parameter int XW        = 10,
    parameter int X_MAX     = 640,
    parameter int N_REGIONS = 4,
    parameter int WINDOW    = 10,
    parameter int THRESH    = 7,
    parameter int MODE      = 0,
    parameter int HOLD      = 1,
    parameter int CW        = $clog2(WINDOW + 1),
    localparam int IW       = (N_REGIONS > 1) ? $clog2(N_REGIONS) : 1
) (
    input  logic                 PCLK,
    input  logic                 reset,
    input  logic                 VSYNC,
    input  logic                 centro_valid,
    input  logic [XW-1:0]        centroX,
    output logic                 en,
    output logic [N_REGIONS-1:0] green_region,
    output logic [IW-1:0]        region_idx,
    output logic                 region_valid
);

    localparam int REGION_W = X_MAX / N_REGIONS;
    localparam int WCW      = $clog2(WINDOW);

    logic                 r_vsync_q;
    logic                 w_strobe;
    logic [WCW-1:0]       r_win_cnt;
    logic                 w_last;
    logic [CW-1:0]        r_cnt      [N_REGIONS];
    logic [CW-1:0]        w_next_cnt [N_REGIONS];
    logic [N_REGIONS-1:0] w_hit;
    logic [N_REGIONS-1:0] w_q;
    logic [IW-1:0]        w_idx;
    logic [31:0]          w_x;

    assign w_strobe = VSYNC & ~r_vsync_q;
    assign w_last   = (r_win_cnt == WCW'(WINDOW - 1));
    assign w_x      = 32'(centroX);

    generate
        for (genvar gi = 0; gi < N_REGIONS; gi++) begin : g_region
            localparam logic [31:0] c_lo = 32'(gi * REGION_W);

            // Unsigned offset wraps to a huge value below the region start.
            assign w_hit[gi] = centro_valid && (w_x < 32'(X_MAX))
                               && ((w_x - c_lo) < 32'(REGION_W));

            if (MODE == 1) begin : g_cumulative
                assign w_next_cnt[gi] = r_cnt[gi] + CW'(w_hit[gi]);
            end else begin : g_run
                assign w_next_cnt[gi] = w_hit[gi] ? (r_cnt[gi] + CW'(1)) : '0;
            end

            assign w_q[gi] = (32'(w_next_cnt[gi]) >= 32'(THRESH));
        end
    endgenerate

    // THRESH above WINDOW/2 leaves at most one qualifying region.
    always_comb begin
        w_idx = '0;
        for (int i = 0; i < N_REGIONS; i++) begin
            if (w_q[i]) begin
                w_idx = IW'(i);
            end
        end
    end

    always_ff @(posedge PCLK) begin
        if (reset) begin
            r_vsync_q    <= 1'b0;
            r_win_cnt    <= '0;
            for (int i = 0; i < N_REGIONS; i++) begin
                r_cnt[i] <= '0;
            end
            en           <= 1'b0;
            green_region <= '0;
            region_idx   <= '0;
            region_valid <= 1'b0;
        end else begin
            r_vsync_q <= VSYNC;
            en        <= 1'b0;
            if (w_strobe) begin
                if (w_last) begin
                    r_win_cnt <= '0;
                    for (int i = 0; i < N_REGIONS; i++) begin
                        r_cnt[i] <= '0;
                    end
                    en <= 1'b1;
                    if (|w_q) begin
                        green_region <= w_q;
                        region_idx   <= w_idx;
                        region_valid <= 1'b1;
                    end else if (HOLD == 0) begin
                        green_region <= '0;
                        region_idx   <= '0;
                        region_valid <= 1'b0;
                    end
                end else begin
                    r_win_cnt <= r_win_cnt + WCW'(1);
                    for (int i = 0; i < N_REGIONS; i++) begin
                        r_cnt[i] <= w_next_cnt[i];
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/region_vote_smoother.md
Name: region_vote_smoother

Overview:
- Temporal smoother for the tracked object's horizontal centroid.
- Splits the X range into N_REGIONS equal-width regions and samples the centroid once per frame on the rising edge of VSYNC.
- Accumulates per-region votes over a window of WINDOW frames, then issues a one-hot region decision plus an update pulse.
- Sits between the centroid extractor and the game/LED logic.
- Successor to the fixed 4-region smoother: parametrised region count, window and threshold; one sample per frame; two counting modes; optional hold; explicit validity.

Parameters:
- XW, 10, width of centroX.
- X_MAX, 640, active width; centroX >= X_MAX is out of range.
- N_REGIONS, 4, number of equal regions; REGION_W = X_MAX / N_REGIONS (must divide exactly).
- WINDOW, 10, frames per decision window (>= 2).
- THRESH, 7, votes needed to select a region; must satisfy WINDOW/2 < THRESH <= WINDOW.
- MODE, 0, 0 = consecutive-run count, 1 = cumulative count.
- HOLD, 1, 1 = keep previous decision when no region qualifies, 0 = clear it.
- CW, $clog2(WINDOW+1), per-region counter width (derived).

Ports:
- PCLK  input  1  pixel clock; the only clock.
- reset  input  1  synchronous, active-high reset.
- VSYNC  input  1  camera vertical sync; level signal, sampled in PCLK domain.
- centro_valid  input  1  centroX holds a valid detection for this frame.
- centroX  input  XW  centroid column.
- en  output  1  one-cycle pulse: a new decision has been loaded.
- green_region  output  N_REGIONS  one-hot decision; bit i = region i.
- region_idx  output  $clog2(N_REGIONS)  index of the set bit; 0 when none set.
- region_valid  output  1  OR of green_region.

Behaviour:
- Reset (sync, PCLK edge with reset=1):
  - All outputs 0.
  - Region counters, window counter and vsync_q cleared.
  - Reset overrides any in-progress window; a partial window is discarded.
- Edge detect:
  - vsync_q <= VSYNC each cycle.
  - strobe = VSYNC & ~vsync_q, i.e. exactly one strobe per frame regardless of VSYNC pulse length.
  - No state other than vsync_q changes on non-strobe cycles, except en clearing.
- Classification (combinational on strobe):
  - hit_i = centro_valid && centroX < X_MAX && i*REGION_W <= centroX < (i+1)*REGION_W.
  - Defaults give regions 0–159, 160–319, 320–479 and 480–639, with no gaps.
- Counting, on strobe:
  - MODE 1: cnt_i += hit_i.
  - MODE 0: cnt_i = hit_i ? cnt_i+1 : 0.
  - Invalid or out-of-range samples still consume a window slot; in MODE 0 they zero every counter.
  - Counters never exceed WINDOW, so no saturation logic is needed.
- Window:
  - win_cnt counts strobes 0..WINDOW-1.
  - On the strobe where win_cnt == WINDOW-1:
    - Evaluate using counts that include the current sample (next_cnt_i).
    - Load outputs at that same clock edge.
    - Clear all cnt_i and win_cnt.
- Decision:
  - q_i = next_cnt_i >= THRESH; the THRESH constraint guarantees at most one q_i is set.
  - If any q_i is set: green_region <= q, region_idx <= i, region_valid <= 1.
  - If none is set and HOLD=1: outputs unchanged.
  - If none is set and HOLD=0: all three outputs <= 0.
- en:
  - 1 for exactly the one PCLK cycle following the evaluating edge.
  - Asserted on every window end, even when the decision is held or unchanged.
  - 0 otherwise.
- Latency: the decision is visible one PCLK after the VSYNC rising edge of the WINDOW-th frame.
- VSYNC high at reset release: vsync_q is 0 after reset, so VSYNC already high produces a strobe on the first cycle. This is intended.

Test Plan:
- Reset, then 10 frames with centroX=200, valid=1 -> en pulses once after frame 10; green_region=4'b0010, region_idx=1, region_valid=1.
- MODE 0: 9 frames at x=500 then 1 frame at x=100 -> run counts are region3=0 and region0=1, none >= 7. HOLD=1 keeps the previous 4'b0010; HOLD=0 gives 4'b0000 with en=1.
- MODE 1, 7 frames at x=330 plus 3 at x=10 in mixed order -> green_region=4'b0100. Same stimulus in MODE 0 with the last three at x=10 -> no selection.
- Boundaries x=159,160,319,320,479,480,639 -> single frames map to regions 0,1,1,2,2,3,3. x=640 and x=1023 hit no region.
- VSYNC held high for 1000 cycles per frame -> exactly one count per frame; the window closes after 10 rising edges, not earlier.
- Assert reset mid-window after 5 frames at x=50, then 10 frames at x=250 -> first en after the 10th post-reset frame; green_region=4'b0010; no influence from pre-reset samples.
